// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter sequencing frames onto one UART transmitter
// Optional WAIT_DONE watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 200_000,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         arb_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_en,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [GW-1:0]                grant_id,
    output logic                         active,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic [GW-1:0]        win_idx, cand;
    logic                 win_found;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_en_q, tx_en_d;
    logic                 active_q, active_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 limit_hit;

    // First pending requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == LAUNCH) begin
            wd_cnt_d = '0;
        end else if (state_q == WAIT_DONE && !tx_done) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
    end

    assign limit_hit = (state_q == WAIT_DONE) && !tx_done &&
                       (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        tx_en_d       = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && !tx_busy && win_found) begin
                    state_d              = LAUNCH;
                    grant_id_d           = win_idx;
                    tx_data_d            = req_data[int'(win_idx)*DATA_BITS +: DATA_BITS];
                    ptr_d                = GW'((int'(win_idx) + 1) % NUM_REQ);
                    tx_en_d              = 1'b1;
                    req_ready_d[win_idx] = 1'b1;
                end
            end
            LAUNCH: state_d = WAIT_DONE;
            WAIT_DONE: begin
                // A completion on the limit cycle takes priority over the watchdog.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (limit_hit) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            tx_en_q       <= 1'b0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            tx_en_q       <= tx_en_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule
